// File: rtl/wash_panel_ctrl.sv
// Coin/panel front end for the washing machine controller.
// Conditions raw switches, tracks credit and drives coin_in/double_wash/timer_pause.

module wash_panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          level_d_q;

  // sync chain, then accept a new level only after a full run of mismatches
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw};
      level_d_q <= level_q;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign evt = level_q & ~level_d_q;

endmodule

module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRICE           = 4,
  parameter int DOUBLE_PRICE    = 6,
  parameter int CREDIT_W        = 4,
  parameter int ACK_TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_raw,
  input  logic                dbl_btn_raw,
  input  logic                pause_btn_raw,
  input  logic [2:0]          machine_state,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic                timer_pause,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [2:0] {
    COLLECT  = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ACK = 3'd2,
    RUNNING  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int AW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] DBL_C   = CREDIT_W'(DOUBLE_PRICE);
  localparam logic [CREDIT_W-1:0] CR_MAX  = '1;

  localparam logic [2:0] MS_IDLE = 3'd0;
  localparam logic [2:0] MS_SPIN = 3'd4;

  state_t state_q;
  state_t state_n;

  logic                coin_evt;
  logic                dbl_evt;
  logic                pause_evt;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W-1:0] price;
  logic                dbl_sel_q;
  logic                dbl_sel_n;
  logic                dw_q;
  logic                tp_q;
  logic                wd_q;
  logic [AW-1:0]       ack_cnt_q;
  logic                afford;
  logic                charge;
  logic                wd_rise;
  logic                spin;
  logic                ack_seen;
  logic                ack_expired;

  wash_panel_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_coin_db (
    .clk(clk),
    .rst(rst),
    .raw(coin_raw),
    .evt(coin_evt)
  );

  wash_panel_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbl_db (
    .clk(clk),
    .rst(rst),
    .raw(dbl_btn_raw),
    .evt(dbl_evt)
  );

  wash_panel_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause_db (
    .clk(clk),
    .rst(rst),
    .raw(pause_btn_raw),
    .evt(pause_evt)
  );

  assign price       = dbl_sel_q ? DBL_C : PRICE_C;
  assign afford      = (credit_q >= price);
  assign charge      = (state_q == COLLECT) && afford;
  assign wd_rise     = wash_done & ~wd_q;
  assign spin        = (machine_state == MS_SPIN);
  assign ack_seen    = (machine_state != MS_IDLE);
  assign ack_expired = (ack_cnt_q == ACK_LAST);

  // panel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_n;
    end
  end

  // session sequencing
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      COLLECT: begin
        if (afford) state_n = LAUNCH;
      end
      LAUNCH: begin
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_seen) begin
          state_n = RUNNING;
        end else if (ack_expired) begin
          state_n = LAUNCH;
        end
      end
      RUNNING: begin
        if (wd_rise) state_n = DONE;
      end
      DONE: begin
        state_n = COLLECT;
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  // pulse and level outputs; pause request drops as soon as spin ends
  always_comb begin
    coin_in     = (state_q == LAUNCH);
    busy        = (state_q != COLLECT);
    double_wash = dw_q;
    timer_pause = tp_q & spin;
    credit      = credit_q;
  end

  // credit charge/add and double-wash selection
  always_comb begin
    credit_n  = credit_q;
    dbl_sel_n = dbl_sel_q;
    if (charge) begin
      credit_n = credit_q - price;
    end
    if (coin_evt && (charge || credit_q != CR_MAX)) begin
      credit_n = credit_n + CREDIT_W'(1);
    end
    if (state_q == COLLECT && dbl_evt) begin
      dbl_sel_n = ~dbl_sel_q;
    end
    if (state_q == DONE) begin
      dbl_sel_n = 1'b0;
    end
  end

  // session datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q  <= '0;
      dbl_sel_q <= 1'b0;
      dw_q      <= 1'b0;
      tp_q      <= 1'b0;
      wd_q      <= 1'b0;
      ack_cnt_q <= '0;
    end else begin
      credit_q  <= credit_n;
      dbl_sel_q <= dbl_sel_n;
      wd_q      <= wash_done;
      if (state_n == LAUNCH) begin
        dw_q <= dbl_sel_n;
      end else if (state_q == DONE) begin
        dw_q <= 1'b0;
      end
      if (state_q == DONE || !spin) begin
        tp_q <= 1'b0;
      end else if (state_q == RUNNING && pause_evt) begin
        tp_q <= ~tp_q;
      end
      if (state_q != WAIT_ACK) begin
        ack_cnt_q <= '0;
      end else if (!ack_seen) begin
        ack_cnt_q <= ack_cnt_q + AW'(1);
      end
    end
  end

endmodule
